// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B transmit sequencer.
package ws2812b_pkg;

  // Serial line phases: HIGH/LOW make up one bit cell, LATCH is the reset gap.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Register map (0x0 .. 3*NPIX-1 are pixel bytes G,R,B per pixel)
  localparam logic [3:0] ADDR_LEN  = 4'hC;
  localparam logic [3:0] ADDR_CTRL = 4'hD;
  localparam logic [3:0] ADDR_STAT = 4'hE;

  // Default timing at 64 MHz
  localparam int DEF_CLK_HZ   = 64000000;
  localparam int DEF_T0H_CYC  = 26;
  localparam int DEF_T1H_CYC  = 51;
  localparam int DEF_TBIT_CYC = 80;
  localparam int DEF_TRST_CYC = 3840;
  localparam int DEF_NPIX     = 4;

  // Phase timer width; comfortably holds the latch time
  localparam int TMR_W = 16;

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Phase down-counter: load with a duration in clocks, expire_o is high
// during the last clock of that duration and stays high until reloaded.
module ws2812b_bit_timer
  import ws2812b_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i - TMR_W'(1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - TMR_W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ws2812b_tx_sequencer.sv
// WS2812B frame sequencer: register-mapped pixel buffer, serialises
// 24*LEN bits (G,R,B, MSB first) then holds the line low for the latch time.
module ws2812b_tx_sequencer
  import ws2812b_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int TRST_CYC = DEF_TRST_CYC,
  parameter int NPIX     = DEF_NPIX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int BYTES = 3 * NPIX;
  localparam int BW    = $clog2(BYTES);

  localparam logic [TMR_W-1:0] T0H_L  = TMR_W'(T0H_CYC);
  localparam logic [TMR_W-1:0] T1H_L  = TMR_W'(T1H_CYC);
  localparam logic [TMR_W-1:0] T0L_L  = TMR_W'(TBIT_CYC - T0H_CYC);
  localparam logic [TMR_W-1:0] T1L_L  = TMR_W'(TBIT_CYC - T1H_CYC);
  localparam logic [TMR_W-1:0] TRST_L = TMR_W'(TRST_CYC);
  localparam logic [2:0]       NPIX_L = 3'(NPIX);

  state_e           state_q, state_d;
  logic [7:0]       pix_q [BYTES];
  logic [2:0]       len_q;
  logic [BW-1:0]    byte_q, nxt_byte;
  logic [2:0]       pos_q, nxt_pos;
  logic             done_q, dout_q, dout_d, busy;
  logic             tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic             start, cur_val, nxt_val, last_bit;
  logic [5:0]       frame_bytes;
  logic             unused_ok;

  assign unused_ok = ^{ui_in, (CLK_HZ > 0)};

  ws2812b_bit_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_exp)
  );

  // Start only takes effect while idle; a busy frame freezes the map
  assign start       = data_write && !busy && (address == ADDR_CTRL) && data_in[0];
  assign frame_bytes = 6'(len_q) * 6'd3;
  assign cur_val     = pix_q[byte_q][pos_q];
  assign last_bit    = (pos_q == 3'd0) && ((6'(byte_q) + 6'd1) == frame_bytes);
  // pos counts 7..0; wrapping 0 -> 7 moves to the next byte
  assign nxt_pos     = pos_q - 3'd1;
  assign nxt_byte    = (pos_q == 3'd0) ? byte_q + BW'(1) : byte_q;
  assign nxt_val     = (int'(nxt_byte) < BYTES) ? pix_q[nxt_byte][nxt_pos] : 1'b0;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and phase-timer reload; each phase loads its own duration
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        tmr_load = 1'b1;
        if (len_q != 3'd0) begin
          state_d = ST_HIGH;
          tmr_val = pix_q[0][7] ? T1H_L : T0H_L;
        end else begin
          state_d = ST_LATCH;
          tmr_val = TRST_L;
        end
      end
      ST_HIGH: if (tmr_exp) begin
        state_d  = ST_LOW;
        tmr_load = 1'b1;
        tmr_val  = cur_val ? T1L_L : T0L_L;
      end
      ST_LOW: if (tmr_exp) begin
        tmr_load = 1'b1;
        if (last_bit) begin
          state_d = ST_LATCH;
          tmr_val = TRST_L;
        end else begin
          state_d = ST_HIGH;
          tmr_val = nxt_val ? T1H_L : T0H_L;
        end
      end
      ST_LATCH: if (tmr_exp) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; dout is registered from the next state
  always_comb begin
    busy   = (state_q != ST_IDLE);
    dout_d = (state_d == ST_HIGH);
  end

  // Pixel buffer, LEN, bit/byte index, done flag and registered dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BYTES; i++) pix_q[i] <= '0;
      len_q  <= 3'd1;
      byte_q <= '0;
      pos_q  <= 3'd7;
      done_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      if (data_write && !busy && (int'(address) < BYTES))
        pix_q[BW'(address)] <= data_in;
      if (data_write && !busy && (address == ADDR_LEN))
        len_q <= (data_in > 8'(NPIX)) ? NPIX_L : data_in[2:0];
      if (start) begin
        byte_q <= '0;
        pos_q  <= 3'd7;
      end else if ((state_q == ST_LOW) && tmr_exp && !last_bit) begin
        byte_q <= nxt_byte;
        pos_q  <= nxt_pos;
      end
      // Frame completion beats a simultaneous clear
      if ((state_q == ST_LATCH) && tmr_exp)
        done_q <= 1'b1;
      else if (data_write && (address == ADDR_STAT))
        done_q <= 1'b0;
    end
  end

  // Combinational register read
  always_comb begin
    data_out = 8'h00;
    if (int'(address) < BYTES)     data_out = pix_q[BW'(address)];
    else if (address == ADDR_LEN)  data_out = {5'b0, len_q};
    else if (address == ADDR_STAT) data_out = {6'b0, done_q, busy};
  end

  assign uo_out = {4'b0, busy, dout_q, 2'b0};

endmodule

// File: tb/tb_ws2812b_tx_sequencer.sv
// Directed bench for ws2812b_tx_sequencer: reset, frame waveform, busy
// freeze, LEN=0 frame, LEN saturation, async mid-frame reset, done priority.
module tb_ws2812b_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int n_chk = 0;
  int n_pass = 0;

  localparam int NCAP = 6000;
  logic cap_d [NCAP];
  logic cap_b [NCAP];
  logic cap_n [NCAP];

  ws2812b_tx_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One-cycle bus write; returns on the negedge after the accepting edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output int v);
    address = a;
    #1 v = int'(data_out);
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input int exp);
    int v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // Sample dout/busy/done once per clock; mode 1 injects writes mid-frame
  task automatic capture(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      data_write = 1'b0;
      address = 4'hE;
      #1;
      cap_d[k] = uo_out[2];
      cap_b[k] = uo_out[3];
      cap_n[k] = data_out[1];
      if (mode == 1) begin
        case (k)
          300:  begin address = 4'h0; data_in = 8'hFF; data_write = 1'b1; end
          400:  begin address = 4'hD; data_in = 8'h01; data_write = 1'b1; end
          500:  begin address = 4'hC; data_in = 8'h02; data_write = 1'b1; end
          5759: begin address = 4'hE; data_in = 8'h00; data_write = 1'b1; end
          default: ;
        endcase
      end
    end
    @(negedge clk);
    data_write = 1'b0;
  endtask

  function automatic int run_len(input int from, input logic val, input int n);
    int c = 0;
    for (int i = from; i < n && cap_d[i] == val; i++) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int i = 0; i < n; i++) if (cap_n[i]) return i;
    return -1;
  endfunction

  // Compare a captured single-pixel frame against the ideal waveform
  task automatic check_frame(input string tag, input logic [23:0] grb, input int n);
    int md = 0, mb = 0;
    logic e;
    for (int k = 0; k < n; k++) begin
      if (k < 1920) e = ((k % 80) < (grb[23 - k/80] ? 51 : 26));
      else          e = 1'b0;
      if (cap_d[k] != e) md++;
      if (cap_b[k] != (k < 5760)) mb++;
    end
    chk({tag, "_dout_wave"}, md, 0);
    chk({tag, "_busy_wave"}, mb, 0);
    chk({tag, "_bit0_high"}, run_len(0, 1'b1, n), 51);
    chk({tag, "_bit0_low"}, run_len(51, 1'b0, n), 29);
    chk({tag, "_bit1_high"}, run_len(80, 1'b1, n), 26);
    chk({tag, "_bit22_high"}, run_len(22*80, 1'b1, n), 26);
    chk({tag, "_bit23_high"}, run_len(23*80, 1'b1, n), 51);
    chk({tag, "_done_at"}, first_done(n), 5760);
  endtask

  initial begin
    int ones, bcnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_uo_out", int'(uo_out), 8'h00);
    chk_rd("rst_len_during", 4'hC, 8'h01);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_uo_after", int'(uo_out), 8'h00);
    chk_rd("rst_len", 4'hC, 8'h01);
    chk_rd("rst_stat", 4'hE, 8'h00);
    chk_rd("rst_pix0", 4'h0, 8'h00);
    chk_rd("rst_unmapped_f", 4'hF, 8'h00);

    // Single pixel G=80 R=00 B=01, LEN=1
    wr(4'h0, 8'h80); wr(4'h1, 8'h00); wr(4'h2, 8'h01);
    chk_rd("pix0_wr", 4'h0, 8'h80);
    chk_rd("pix2_wr", 4'h2, 8'h01);
    wr(4'hD, 8'h01);
    capture(5800, 0);
    check_frame("f1", 24'h800001, 5800);
    chk_rd("f1_stat", 4'hE, 8'h02);
    chk_rd("f1_ctrl_rd", 4'hD, 8'h00);

    // Frozen map during a frame; done set wins over a same-cycle clear
    wr(4'hE, 8'h00);
    chk_rd("clr_done", 4'hE, 8'h00);
    wr(4'hD, 8'h01);
    capture(5800, 1);
    check_frame("f2", 24'h800001, 5800);
    chk_rd("f2_pix0_kept", 4'h0, 8'h80);
    chk_rd("f2_len_kept", 4'hC, 8'h01);
    chk_rd("f2_done_won", 4'hE, 8'h02);
    wr(4'hE, 8'h00);
    chk_rd("f2_done_clr", 4'hE, 8'h00);

    // LEN=0: latch only
    wr(4'hC, 8'h00);
    chk_rd("len0", 4'hC, 8'h00);
    wr(4'hD, 8'h01);
    capture(3900, 0);
    ones = 0; bcnt = 0;
    for (int k = 0; k < 3900; k++) begin
      if (cap_d[k]) ones++;
      if (cap_b[k]) bcnt++;
    end
    chk("len0_dout_high", ones, 0);
    chk("len0_busy_len", bcnt, 3840);
    chk("len0_done_at", first_done(3900), 3840);
    wr(4'hC, 8'h07);
    chk_rd("len_sat7", 4'hC, 8'h04);
    wr(4'hC, 8'h03);
    chk_rd("len3", 4'hC, 8'h03);

    // Async reset at clock 500 of a frame (bit 6, dout high)
    wr(4'hC, 8'h01); wr(4'h5, 8'hA5); wr(4'hE, 8'h00);
    chk_rd("pix5_wr", 4'h5, 8'hA5);
    wr(4'hD, 8'h01);
    repeat (500) @(negedge clk);
    chk("mid_uo_before", int'(uo_out), 8'h0C);
    #2 rst_n = 1'b0;
    #1 chk("mid_uo_async", int'(uo_out), 8'h00);
    chk_rd("mid_stat_async", 4'hE, 8'h00);
    @(negedge clk);
    chk_rd("mid_len_in_rst", 4'hC, 8'h01);
    @(negedge clk) rst_n = 1'b1;
    chk_rd("mid_pix0_clr", 4'h0, 8'h00);
    chk_rd("mid_pix5_clr", 4'h5, 8'h00);
    chk_rd("mid_len_after", 4'hC, 8'h01);
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (uo_out != 8'h00) ones++;
    end
    chk("mid_uo_quiet", ones, 0);
    chk_rd("mid_stat_after", 4'hE, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ws2812b_tx_sequencer.md
WS2812B_TX_SEQUENCER -- requirements
Module: ws2812b_tx_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 64000000, meaning system clock frequency.
REQ-002 SHALL have parameter T0H_CYC, default 26, meaning high time of a 0 bit in clocks (0.4 us).
REQ-003 SHALL have parameter T1H_CYC, default 51, meaning high time of a 1 bit in clocks (0.8 us).
REQ-004 SHALL have parameter TBIT_CYC, default 80, meaning total bit period in clocks (1.25 us).
REQ-005 SHALL have parameter TRST_CYC, default 3840, meaning latch low time in clocks (60 us).
REQ-006 SHALL have parameter NPIX, default 4, meaning pixel buffer depth.
REQ-007 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 ui_in  input  8  input PMOD, unused.
REQ-010 uo_out  output  8  [2]=serial LED data (dout), [3]=busy, all other bits 0.
REQ-011 address  input  4  register address.
REQ-012 data_write  input  1  one-cycle write strobe.
REQ-013 data_in  input  8  write data, valid with data_write.
REQ-014 data_out  output  8  read data, combinational from address.

Function
REQ-015 Map 0x0-0xB SHALL be pixel bytes, pixel n at 3n (G), 3n+1 (R), 3n+2 (B); read/write.
REQ-016 Map 0xC SHALL be LEN[2:0] (pixels per frame); writes above NPIX saturate to NPIX; reads return stored value zero-extended.
REQ-017 Map 0xD write with data_in[0]=1 SHALL start a frame; reads return 0x00.
REQ-018 Map 0xE read SHALL return {6'b0, done, busy}; any write SHALL clear done.
REQ-019 Map 0xF and any unmapped read SHALL return 0x00.
REQ-020 FSM states SHALL be IDLE, HIGH, LOW, LATCH.
REQ-021 IDLE + start write at cycle t: LEN>0 -> HIGH from t+1 (dout=1 at t+1); LEN=0 -> LATCH from t+1.
REQ-022 Bit order SHALL be pixel 0 first, G,R,B within a pixel, MSB first within a byte.
REQ-023 HIGH SHALL last T1H_CYC clocks for a 1 bit and T0H_CYC for a 0 bit, then LOW.
REQ-024 LOW SHALL last TBIT_CYC minus the high time, so every bit occupies exactly TBIT_CYC clocks.
REQ-025 After LOW of the last bit (24*LEN bits), SHALL enter LATCH; else HIGH of the next bit with no gap.
REQ-026 LATCH SHALL hold dout=0 for TRST_CYC clocks, then IDLE, set done, clear busy on the same edge.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 While busy, writes to 0x0-0xD SHALL be ignored (buffer, LEN and start frozen); 0xE writes still clear done.
REQ-029 done set and 0xE clear write in the same cycle: set SHALL win.
REQ-030 dout SHALL be registered (no combinational path from bus inputs).
REQ-031 Bit and byte counters SHALL be sized for 24*NPIX bits; no wrap within a frame.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, dout=0, busy=0, done=0, LEN=1, all pixel bytes 0x00.
REQ-033 Reset mid-frame SHALL abort without completing the bit or latch; no done set.
REQ-034 uo_out SHALL be 0x00 and data_out at 0xC SHALL read 0x01 during and after reset.

Structure
REQ-035 Package ws2812b_pkg SHALL hold the state enum, register address constants and default timing constants.
REQ-036 Sub-module ws2812b_bit_timer SHALL own the phase down-counter (load value, expire pulse); sequencer owns FSM, buffer, bit index.

Verification
REQ-037 Reset -> uo_out=0x00, read 0xC=0x01, read 0xE=0x00, read 0x0=0x00.
REQ-038 Pixel0 G=0x80 R=0x00 B=0x01, LEN=1, start -> bit0 high 51/low 29, bits1-22 high 26/low 54, bit23 high 51/low 29, then 3840 low; done=1 at clock 1920+3840 after t+1.
REQ-039 Start during frame, write 0x0=0xFF mid-frame -> waveform unchanged, 0x0 reads old value, single done.
REQ-040 LEN=0 then start -> dout never high, busy 3840 clocks, done=1; write LEN=7 -> reads 0x04.
REQ-041 rst_n low at clock 500 of a frame -> dout=0 and busy=0 asynchronously, done=0, buffer cleared.
REQ-042 0xE write on the clock done sets -> done reads 1; next 0xE write -> done reads 0.
